// File: rtl/frac_logic_ccff_loader.sv
// Configuration-chain sequencer for one frac_logic tile: serialises bitstream words onto
// ccff_head, gates the chain shift, and optionally recirculates the chain once to verify it.
`timescale 1ns/1ps
module frac_logic_ccff_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WBIT = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHIFT  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WORD_W-1:0]    r_wreg;
  logic [WB_W-1:0]      r_wbit;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [CNT_W-1:0]     r_vcnt;
  logic [CHAIN_LEN-1:0] r_shadow;
  logic                 r_verify_err;
  logic                 w_chain_full;
  logic                 w_word_end;
  logic                 w_verify_last;

  // The chain-length test wins over the word test, which truncates the last word.
  assign w_chain_full  = (r_bit_cnt == LAST_BIT);
  assign w_word_end    = (r_wbit == LAST_WBIT);
  assign w_verify_last = (r_vcnt == LAST_BIT);
  assign verify_err    = r_verify_err;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_state_next = S_LOAD;
      S_LOAD:   if (cfg_valid) w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (w_chain_full) begin
          w_state_next = VERIFY_EN ? S_VERIFY : S_DONE;
        end else if (w_word_end) begin
          w_state_next = S_LOAD;
        end
      end
      S_VERIFY: if (w_verify_last) w_state_next = S_DONE;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready     = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (r_state)
      S_IDLE:   busy = 1'b0;
      S_LOAD:   cfg_ready = 1'b1;
      S_SHIFT: begin
        ccff_shift_en = 1'b1;
        ccff_head     = r_wreg[0];
      end
      S_VERIFY: begin
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
      end
      S_DONE:   done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_wreg       <= '0;
      r_wbit       <= '0;
      r_bit_cnt    <= '0;
      r_vcnt       <= '0;
      r_shadow     <= '0;
      r_verify_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bit_cnt    <= '0;
            r_vcnt       <= '0;
            r_verify_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            r_wreg <= cfg_data;
            r_wbit <= '0;
          end
        end
        S_SHIFT: begin
          r_wreg              <= r_wreg >> 1;
          r_wbit              <= r_wbit + 1'b1;
          r_bit_cnt           <= r_bit_cnt + 1'b1;
          r_shadow[r_bit_cnt] <= r_wreg[0];
        end
        S_VERIFY: begin
          // Bits leave the tail in the same order they were shifted in.
          r_vcnt <= r_vcnt + 1'b1;
          if (ccff_tail != r_shadow[r_vcnt]) r_verify_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_logic_ccff_loader.sv
// Self-checking bench for frac_logic_ccff_loader: two instances (verify on/off), each
// driving a behavioural 20-flop chain model gated by ccff_shift_en.
`timescale 1ns/1ps
module tb_frac_logic_ccff_loader;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sel = 1'b0;
  logic cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic [L-1:0] chain0 = '0;
  logic [L-1:0] chain1 = '0;
  logic [L-1:0] stuck0 = '0;
  logic rdy0, head0, shen0, busy0, done0, err0;
  logic rdy1, head1, shen1, busy1, done1, err1;
  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  frac_logic_ccff_loader #(.CHAIN_LEN(L), .WORD_W(8), .VERIFY_EN(1'b1)) dut (
    .prog_clk(clk), .pReset(rst), .start(start & ~sel), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy0), .ccff_head(head0), .ccff_tail(chain0[L-1]),
    .ccff_shift_en(shen0), .busy(busy0), .done(done0), .verify_err(err0)
  );

  frac_logic_ccff_loader #(.CHAIN_LEN(L), .WORD_W(8), .VERIFY_EN(1'b0)) dut_nv (
    .prog_clk(clk), .pReset(rst), .start(start & sel), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(rdy1), .ccff_head(head1), .ccff_tail(chain1[L-1]),
    .ccff_shift_en(shen1), .busy(busy1), .done(done1), .verify_err(err1)
  );

  // Chain models: bit 0 is the head-side flop, bit L-1 drives ccff_tail.
  always @(posedge clk) if (shen0) chain0 <= {chain0[L-2:0], head0} & ~stuck0;
  always @(posedge clk) if (shen1) chain1 <= {chain1[L-2:0], head1};

  wire rdy_s  = sel ? rdy1  : rdy0;
  wire shen_s = sel ? shen1 : shen0;
  wire busy_s = sel ? busy1 : busy0;
  wire done_s = sel ? done1 : done0;
  wire err_s  = sel ? err1  : err0;
  wire [L-1:0] chain_s = sel ? chain1 : chain0;
  wire [5:0] outs0 = {rdy0, head0, shen0, busy0, done0, err0};
  wire [5:0] outs1 = {rdy1, head1, shen1, busy1, done1, err1};

  // Expected chain: stream bit k ends k places from the tail.
  function automatic logic [L-1:0] exp_chain(input logic [7:0] w0, w1, w2);
    logic [23:0] stream;
    logic [L-1:0] c;
    stream = {w2, w1, w0};
    c = '0;
    for (int k = 0; k < L; k++) c[L-1-k] = stream[k];
    return c;
  endfunction

  // One LOAD cycle per word plus bubbles, one SHIFT per chain bit, optional full recirculation.
  function automatic int exp_done(input int gaps, input bit ven);
    int nwords;
    nwords = (L + 7) / 8;
    return nwords + gaps + L + (ven ? L : 0) + 1;
  endfunction

  task automatic do_load(input logic [7:0] w0, w1, w2, input int g0, g1, g2,
                         input bit hold_start, input bit junk,
                         output int done_cyc, output int shen_cnt, output int gap_shen,
                         output logic err_c1);
    logic [7:0] words [3];
    int gap [3];
    int wi;
    words = '{w0, w1, w2};
    gap = '{g0, g1, g2};
    wi = 0; done_cyc = -1; shen_cnt = 0; gap_shen = 0; err_c1 = 1'bx;
    @(negedge clk);
    start = 1'b1;
    cfg_valid = (g0 == 0);
    cfg_data = w0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (cyc == 1) err_c1 = err_s;
      if (shen_s) shen_cnt++;
      if (done_s) begin
        done_cyc = cyc;
        break;
      end
      if (wi < 3 && rdy_s) begin
        if (gap[wi] > 0) begin
          cfg_valid = 1'b0;
          gap[wi]--;
          if (shen_s) gap_shen++;
        end else begin
          cfg_valid = 1'b1;
          cfg_data = words[wi];
          wi++;
        end
      end else if (junk) begin
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_data = 8'($urandom);
      end else if (wi < 3) begin
        cfg_valid = 1'b1;
        cfg_data = words[wi];
      end else begin
        cfg_valid = 1'b0;
      end
    end
    cfg_valid = 1'b0;
    $display("load dut%0d words %h %h %h gaps %0d/%0d/%0d done_cycle %0d verify_err %0b chain %h",
             sel, w0, w1, w2, g0, g1, g2, done_cyc, err_s, chain_s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (outs0 !== 6'b0) $display("FAIL reset_outs_dut0: got %b want 000000", outs0);
    else pass_cnt++;
    chk_cnt++;
    if (outs1 !== 6'b0) $display("FAIL reset_outs_dut1: got %b want 000000", outs1);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (outs0 !== 6'b0) $display("FAIL idle_outs_dut0: got %b want 000000", outs0);
    else pass_cnt++;
  endtask

  task automatic test_full_load();
    int dc, sc, gs;
    logic e1;
    sel = 1'b0;
    do_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 1'b0, 1'b0, dc, sc, gs, e1);
    chk_cnt++;
    if (dc !== exp_done(0, 1'b1)) $display("FAIL full_done_cycle: got %0d want %0d", dc, exp_done(0, 1'b1));
    else pass_cnt++;
    chk_cnt++;
    if (chain_s !== exp_chain(8'hA5, 8'h3C, 8'h0F))
      $display("FAIL full_chain: got %h want %h", chain_s, exp_chain(8'hA5, 8'h3C, 8'h0F));
    else pass_cnt++;
    chk_cnt++;
    if (err_s !== 1'b0) $display("FAIL full_verify_err: got %b want 0", err_s);
    else pass_cnt++;
    chk_cnt++;
    if (sc !== 2 * L) $display("FAIL full_shift_cycles: got %0d want %0d", sc, 2 * L);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({busy_s, done_s} !== 2'b00) $display("FAIL full_back_idle: got busy,done=%b want 00", {busy_s, done_s});
    else pass_cnt++;
  endtask

  task automatic test_stuck();
    int dc, sc, gs;
    logic e1;
    logic want;
    sel = 1'b0;
    stuck0 = '0;
    stuck0[0] = 1'b1;
    // Every bit passes the head-side flop, so any 1 in the stream must be reported.
    want = |{4'h0F & 4'hF, 8'h3C, 8'hA5};
    do_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 1'b0, 1'b0, dc, sc, gs, e1);
    chk_cnt++;
    if (err_s !== want) $display("FAIL stuck_err_at_done: got %b want %b", err_s, want);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (err_s !== want || busy_s !== 1'b0)
      $display("FAIL stuck_err_in_idle: got err=%b busy=%b want err=%b busy=0", err_s, busy_s, want);
    else pass_cnt++;
    stuck0 = '0;
    do_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0, 1'b0, 1'b0, dc, sc, gs, e1);
    chk_cnt++;
    if (e1 !== 1'b0) $display("FAIL stuck_err_cleared_on_start: got %b want 0", e1);
    else pass_cnt++;
    chk_cnt++;
    if (err_s !== 1'b0 || chain_s !== exp_chain(8'hA5, 8'h3C, 8'h0F))
      $display("FAIL stuck_reload: got err=%b chain=%h want err=0 chain=%h", err_s, chain_s,
               exp_chain(8'hA5, 8'h3C, 8'h0F));
    else pass_cnt++;
  endtask

  task automatic test_gap();
    int dc, sc, gs;
    logic e1;
    sel = 1'b0;
    do_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 5, 1'b0, 1'b0, dc, sc, gs, e1);
    chk_cnt++;
    if (dc !== exp_done(5, 1'b1)) $display("FAIL gap_done_cycle: got %0d want %0d", dc, exp_done(5, 1'b1));
    else pass_cnt++;
    chk_cnt++;
    if (gs !== 0) $display("FAIL gap_shift_en_during_bubble: got %0d cycles want 0", gs);
    else pass_cnt++;
    chk_cnt++;
    if (chain_s !== exp_chain(8'hA5, 8'h3C, 8'h0F) || err_s !== 1'b0)
      $display("FAIL gap_chain: got %h err=%b want %h err=0", chain_s, err_s, exp_chain(8'hA5, 8'h3C, 8'h0F));
    else pass_cnt++;
  endtask

  task automatic test_no_verify();
    int dc, sc, gs;
    logic e1;
    sel = 1'b1;
    do_load(8'hFF, 8'hFF, 8'h0F, 0, 0, 0, 1'b0, 1'b0, dc, sc, gs, e1);
    chk_cnt++;
    if (dc !== exp_done(0, 1'b0)) $display("FAIL nv_done_cycle: got %0d want %0d", dc, exp_done(0, 1'b0));
    else pass_cnt++;
    chk_cnt++;
    if (sc !== L) $display("FAIL nv_shift_cycles: got %0d want %0d", sc, L);
    else pass_cnt++;
    chk_cnt++;
    if (chain_s !== exp_chain(8'hFF, 8'hFF, 8'h0F))
      $display("FAIL nv_chain: got %h want %h", chain_s, exp_chain(8'hFF, 8'hFF, 8'h0F));
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({shen_s, busy_s} !== 2'b00) $display("FAIL nv_idle: got shen,busy=%b want 00", {shen_s, busy_s});
    else pass_cnt++;
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    int dc, sc, gs;
    logic e1;
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (outs0 !== 6'b0) $display("FAIL midreset_outs: got %b want 000000", outs0);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cfg_valid = 1'b0;
    do_load(8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b0, dc, sc, gs, e1);
    chk_cnt++;
    if (chain_s !== '0 || err_s !== 1'b0 || dc !== exp_done(0, 1'b1))
      $display("FAIL midreset_reload: got chain=%h err=%b done=%0d want 0/0/%0d",
               chain_s, err_s, dc, exp_done(0, 1'b1));
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    int dc, sc, gs;
    logic e1;
    logic [7:0] w [3];
    sel = 1'b0;
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    do_load(w[0], w[1], w[2], 0, 0, 0, 1'b1, 1'b1, dc, sc, gs, e1);
    chk_cnt++;
    if (dc !== exp_done(0, 1'b1) || chain_s !== exp_chain(w[0], w[1], w[2]))
      $display("FAIL held_load: got done=%0d chain=%h want %0d %h", dc, chain_s,
               exp_done(0, 1'b1), exp_chain(w[0], w[1], w[2]));
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (busy_s !== 1'b0) $display("FAIL held_idle_gap: got busy=%b want 0", busy_s);
    else pass_cnt++;
    start = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (busy_s !== 1'b0) $display("FAIL held_no_restart: got busy=%b want 0", busy_s);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int dc, sc, gs;
    logic e1;
    logic [7:0] w [3];
    int g [3];
    bit junk;
    for (int it = 0; it < 4; it++) begin
      sel = 1'($urandom_range(0, 1));
      junk = 1'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) begin
        w[i] = 8'($urandom);
        g[i] = $urandom_range(0, 3);
      end
      do_load(w[0], w[1], w[2], g[0], g[1], g[2], 1'b0, junk, dc, sc, gs, e1);
      chk_cnt++;
      if (dc !== exp_done(g[0] + g[1] + g[2], !sel))
        $display("FAIL rand_done_cycle[%0d]: got %0d want %0d", it, dc, exp_done(g[0] + g[1] + g[2], !sel));
      else pass_cnt++;
      chk_cnt++;
      if (chain_s !== exp_chain(w[0], w[1], w[2]) || err_s !== 1'b0)
        $display("FAIL rand_chain[%0d]: got %h err=%b want %h err=0", it, chain_s, err_s,
                 exp_chain(w[0], w[1], w[2]));
      else pass_cnt++;
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_stuck();
    test_gap();
    test_no_verify();
    test_reset_mid();
    test_start_held();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
